// File: rtl/tlc_param.sv
`timescale 1ns/1ps
// tlc_param: parametrised highway/farm traffic light controller with tick prescaler,
// all-red clearances and an actuated farm green. Define TLC_PED_EN for the pedestrian input.
module tlc_param #(
   parameter int TICK_DIV = 10,
   parameter int T_HMIN   = 8,
   parameter int T_YEL    = 3,
   parameter int T_AR     = 1,
   parameter int T_FMIN   = 4,
   parameter int T_FMAX   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car_farm,
`ifdef TLC_PED_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   output logic [2:0] light_hwy,
   output logic [2:0] light_farm,
   output logic [2:0] state_o
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int T_MAX = max2(max2(max2(T_HMIN, T_YEL), max2(T_AR, T_FMIN)), T_FMAX);
   localparam int TW    = $clog2(T_MAX) + 1;
   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] HMIN_C  = TW'(T_HMIN);
   localparam logic [TW-1:0] FMIN_C  = TW'(T_FMIN);
   localparam logic [TW-1:0] FMAX_C  = TW'(T_FMAX);
   localparam logic [TW-1:0] HMIN_M1 = TW'(T_HMIN - 1);
   localparam logic [TW-1:0] YEL_M1  = TW'(T_YEL - 1);
   localparam logic [TW-1:0] AR_M1   = TW'(T_AR - 1);
   localparam logic [TW-1:0] FMIN_M1 = TW'(T_FMIN - 1);
   localparam logic [TW-1:0] FMAX_M1 = TW'(T_FMAX - 1);

   generate
      if (TICK_DIV < 1 || T_HMIN < 1 || T_YEL < 1 || T_AR < 1 ||
          T_FMIN < 1 || T_FMAX < 1 || T_FMIN > T_FMAX) begin : g_param_check
         $error("tlc_param: illegal timing parameters");
      end
   endgenerate

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      FG  = 3'd3,
      FY  = 3'd4,
      AR2 = 3'd5
   } state_t;

   state_t          state;
   state_t          nxt;
   logic            car_meta;
   logic            car_s;
   logic            req;
   logic            req_src;
   logic            early_ok;
   logic [PW-1:0]   presc;
   logic [TW-1:0]   timer;
   logic            tick;
   logic            timer_sat;
   logic            enter_fg;
   logic            done_hmin;
   logic            done_yel;
   logic            done_ar;
   logic            done_fmin;
   logic            done_fmax;
   logic            hmin_ok;
   logic            fmin_ok;

   // Two-flop synchroniser; the raw sensor is not used anywhere else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         car_meta <= 1'b0;
         car_s    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep both flops sampling the pre-edge values.
         car_meta <= car_farm;
         car_s    <= car_meta;
      end
   end

`ifdef TLC_PED_EN
   logic ped_meta;
   logic ped_s;
   logic ped_pend;
   logic ped_fg;

   // ped_fg remembers whether a pedestrian was waiting when the current FG began.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ped_meta <= 1'b0;
         ped_s    <= 1'b0;
         ped_pend <= 1'b0;
         ped_fg   <= 1'b0;
      end else begin
         ped_meta <= ped_req;
         ped_s    <= ped_meta;
         if (enter_fg) begin
            ped_pend <= 1'b0;
            ped_fg   <= ped_pend;
         end else if (ped_s && state != FG) begin
            ped_pend <= 1'b1;
         end
      end
   end

   assign req_src  = car_s | ped_s;
   assign early_ok = ~ped_fg;
`else
   assign req_src  = car_s;
   assign early_ok = 1'b1;
`endif

   assign tick      = (presc == P_LAST);
   assign done_hmin = tick && (timer == HMIN_M1);
   assign done_yel  = tick && (timer == YEL_M1);
   assign done_ar   = tick && (timer == AR_M1);
   assign done_fmin = tick && (timer == FMIN_M1);
   assign done_fmax = tick && (timer == FMAX_M1);
   assign hmin_ok   = (timer >= HMIN_C) || done_hmin;
   assign fmin_ok   = (timer >= FMIN_C) || done_fmin;
   assign timer_sat = (state == HG && timer == HMIN_C) || (state == FG && timer == FMAX_C);
   assign enter_fg  = (nxt == FG) && (state != FG);

   always_comb begin
      // NOTE: default first so every path assigns nxt and no latch is inferred.
      nxt = state;
      case (state)
         HG:      if (req && hmin_ok) nxt = HY;
         HY:      if (done_yel) nxt = AR1;
         AR1:     if (done_ar) nxt = FG;
         FG:      if (done_fmax || (!car_s && early_ok && fmin_ok)) nxt = FY;
         FY:      if (done_yel) nxt = AR2;
         AR2:     if (done_ar) nxt = HG;
         default: nxt = HG;
      endcase
   end

   // Both counters restart on every state change so each phase is exactly N*TICK_DIV clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         timer <= '0;
      end else if (nxt != state) begin
         presc <= '0;
         timer <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick && !timer_sat) timer <= timer + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req <= 1'b0;
      end else if (enter_fg) begin
         req <= 1'b0;
      end else if (req_src && state != FG) begin
         req <= 1'b1;
      end
   end

   function automatic logic [2:0] hwy_lamps(input state_t s);
      case (s)
         HG:      return 3'b001;
         HY:      return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] farm_lamps(input state_t s);
      case (s)
         FG:      return 3'b001;
         FY:      return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   // Lamps are registered from the next state, so they always match the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HG;
         light_hwy  <= 3'b001;
         light_farm <= 3'b100;
         state_o    <= 3'd0;
`ifdef TLC_PED_EN
         walk       <= 1'b0;
`endif
      end else begin
         state      <= nxt;
         light_hwy  <= hwy_lamps(nxt);
         light_farm <= farm_lamps(nxt);
         state_o    <= nxt;
`ifdef TLC_PED_EN
         walk       <= (nxt == FG);
`endif
      end
   end

endmodule

// File: doc/tlc_param.md
Name: tlc_param

Overview:
- Parametrised two-road (highway/farm) traffic light controller.
- Adds to the basic controller: an internal tick prescaler, per-phase tick durations, all-red clearance phases, a highway minimum green, and a farm green that is vehicle-actuated with a min/max bound.
- Synchronises the raw farm vehicle sensor internally.
- Sits between the top-level pin wrapper (ui_in/uo_out) and the lamp drivers.

Parameters:
- TICK_DIV, 10: clocks per timing tick; legal range ≥1.
- T_HMIN, 8: minimum highway green, in ticks.
- T_YEL, 3: yellow duration, in ticks; used by both roads.
- T_AR, 1: all-red clearance duration, in ticks; used by both clearances.
- T_FMIN, 4: minimum farm green, in ticks.
- T_FMAX, 10: maximum farm green, in ticks.
- Legality: every T_* ≥1 and T_FMIN ≤ T_FMAX. Elaboration fails (generate-time error) otherwise.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- car_farm  in  1  raw farm vehicle sensor; asynchronous to clk.
- light_hwy  out  3  highway lamps {red, yellow, green}; one-hot.
- light_farm  out  3  farm lamps {red, yellow, green}; one-hot.
- state_o  out  3  current FSM state code, for debug.

Behaviour:
- States and encodings:
  - HG (0): highway green, farm red.
  - HY (1): highway yellow, farm red.
  - AR1 (2): both red.
  - FG (3): highway red, farm green.
  - FY (4): highway red, farm yellow.
  - AR2 (5): both red.
- Codes 6 and 7 are illegal and go to HG on the next clock.
- Outputs:
  - Lamps are a pure decode of the registered state; no combinational path from inputs.
  - Reset values: state=HG, light_hwy=3'b001, light_farm=3'b100, state_o=0.
- Synchroniser:
  - car_farm passes through a 2-flop synchroniser to give car_s.
  - The raw input is used nowhere else.
- Request latch req:
  - Set on any clock where car_s=1 and state is not FG.
  - Cleared on the clock that enters FG.
  - Reset value 0.
- Timing:
  - Prescaler counts 0..TICK_DIV-1; it emits tick on the cycle its count equals TICK_DIV-1, then wraps to 0.
  - Phase timer counts ticks.
  - On every state change, both the prescaler and the phase timer clear to 0.
  - A phase of N ticks therefore lasts exactly N*TICK_DIV clocks.
- Phase timer width: clog2(max T_*)+1 bits.
- Saturation: in HG the phase timer saturates at T_HMIN, and in FG at T_FMAX. No wrap-around.
- done(N) means the phase timer equals N-1 and tick is high, i.e. the phase ends at that clock edge.
- Transitions, evaluated at each rising edge:
  - HG→HY when req=1 and the HG minimum has elapsed (timer reached T_HMIN, or done(T_HMIN) this cycle). Otherwise stay in HG indefinitely.
  - HY→AR1 on done(T_YEL).
  - AR1→FG on done(T_AR).
  - FG→FY on done(T_FMAX).
  - FG→FY early when car_s=0 and at least T_FMIN ticks have elapsed; takes effect on the first such cycle.
  - FY→AR2 on done(T_YEL).
  - AR2→HG on done(T_AR).
- Boundary cases:
  - Request arriving in HG before T_HMIN: held in req; served as soon as the minimum elapses.
  - Request arriving in FY or AR2: sets req; the next HG leaves after exactly T_HMIN ticks.
  - car_s dropping in FG before T_FMIN: FG still lasts T_FMIN ticks.
  - car_s held high throughout FG: FG lasts exactly T_FMAX ticks.
  - TICK_DIV=1: tick is permanently 1.
  - Reset mid-phase: immediate return to HG with req, synchroniser, prescaler and timer all cleared.
- Lamp safety: no state drives green or yellow on both roads at once.

Optional Feature:
- Macro: TLC_PED_EN.
- When defined:
  - Adds port ped_req (in, 1): pedestrian crossing request for the highway crossing; asynchronous, with its own 2-flop synchroniser.
  - Adds port walk (out, 1): high exactly while in FG; reset value 0.
  - A synchronised ped_req sets req under the same rule as car_s.
  - A separate latch ped_pend is set under the same rule as req and cleared on entering FG.
  - If ped_pend was set on FG entry, the early-exit path is disabled for that FG, so it lasts the full T_FMAX.
- When undefined: ped_req and walk ports are absent; behaviour is exactly as above.

Test Plan:
All scenarios use TICK_DIV=1 and the default T_* values.
- Reset then car_farm=0 for 100 clocks: state stays HG; light_hwy=001, light_farm=100 throughout.
- car_farm held 1 from reset release:
  - Sequence HG 8 clocks, HY 3, AR1 1, FG 10, FY 3, AR2 1, then HG.
  - Second HG lasts 8 clocks, since req is re-set during FY/AR2.
- car_farm pulsed 1 for 3 clocks at cycle 20: req latched; HY entered about 3 clocks after the pulse; FG lasts 4 clocks (early exit at T_FMIN).
- car_farm pulsed in HG at cycle 2: held in req; HY entered exactly at cycle 8.
- rst asserted for 1 clock mid-FG: lamps return immediately to hwy=001, farm=100; req=0; no transition until a new request.
- TICK_DIV=4 with car_farm held 1: HY lasts 12 clocks, AR1 4, FG 40.
- TLC_PED_EN defined: ped_req pulse only →
  - FG lasts 10 clocks despite car_farm=0.
  - walk=1 for exactly those 10 clocks.
